// File: rtl/channel_selector.sv
// Initial-selection sequencer for the bus-and-tag channel: address, select,
// command and status handshake with the device, reporting a result code.
module channel_selector #(
    parameter int ADDR_SETUP = 4,
    parameter int TIMEOUT    = 65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       start,
    input  logic [7:0] address,
    input  logic [7:0] command,
    output logic       ready,
    output logic       done,
    output logic [2:0] result,
    output logic [7:0] status,
    output logic [7:0] bus_out,
    output logic       bus_out_parity,
    output logic       operational_out,
    output logic       address_out,
    output logic       select_out,
    output logic       hold_out,
    output logic       command_out,
    output logic       service_out,
    input  logic [7:0] bus_in,
    input  logic       bus_in_parity,
    input  logic       operational_in,
    input  logic       address_in,
    input  logic       select_in,
    input  logic       status_in
);

    typedef enum logic [3:0] {
        S_IDLE, S_SETUP, S_WAIT_OP, S_WAIT_AIN, S_WAIT_ADROP,
        S_WAIT_ST, S_WAIT_SDROP, S_DROP, S_RELEASE
    } state_e;

    localparam logic [2:0] R_OK      = 3'd0;
    localparam logic [2:0] R_NO_DEV  = 3'd1;
    localparam logic [2:0] R_ADDR    = 3'd2;
    localparam logic [2:0] R_PARITY  = 3'd3;
    localparam logic [2:0] R_TIMEOUT = 3'd4;

    localparam logic [15:0] SETUP_LAST = 16'(ADDR_SETUP - 1);
    localparam logic [15:0] TO_LAST    = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [7:0]  bus_q, bus_d;
    logic        par_q;
    logic [7:0]  status_q, status_d;
    logic [2:0]  result_q, result_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        op_q;
    logic        aout_q, aout_d;
    logic        sel_q, sel_d;
    logic        hold_q, hold_d;
    logic        cout_q, cout_d;
    logic        svc_q, svc_d;
    logic [2:0]  err;
    logic        tmo;
    logic        in_par_ok;

    assign tmo       = (cnt_q == TO_LAST);
    assign in_par_ok = ^{bus_in, bus_in_parity};

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cmd_d    = cmd_q;
        bus_d    = bus_q;
        status_d = status_q;
        result_d = result_q;
        done_d   = 1'b0;
        aout_d   = aout_q;
        sel_d    = sel_q;
        hold_d   = hold_q;
        cout_d   = cout_q;
        svc_d    = svc_q;
        err      = R_OK;
        unique case (state_q)
            S_IDLE: begin
                if (start && ready_q) begin
                    addr_d   = address;
                    cmd_d    = command;
                    bus_d    = address;
                    aout_d   = 1'b1;
                    result_d = R_OK;
                    status_d = 8'h00;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    sel_d   = 1'b1;
                    hold_d  = 1'b1;
                    state_d = S_WAIT_OP;
                end
            end
            S_WAIT_OP: begin
                if (operational_in) begin
                    aout_d  = 1'b0;
                    state_d = S_WAIT_AIN;
                end else if (select_in) begin
                    err     = R_NO_DEV;
                    state_d = S_DROP;
                end else if (tmo) begin
                    err     = R_TIMEOUT;
                    state_d = S_DROP;
                end
            end
            S_WAIT_AIN: begin
                if (address_in) begin
                    if (!in_par_ok) begin
                        err     = R_PARITY;
                        state_d = S_DROP;
                    end else if (bus_in != addr_q) begin
                        err     = R_ADDR;
                        state_d = S_DROP;
                    end else begin
                        bus_d   = cmd_q;
                        cout_d  = 1'b1;
                        state_d = S_WAIT_ADROP;
                    end
                end else if (tmo) begin
                    err     = R_TIMEOUT;
                    state_d = S_DROP;
                end
            end
            S_WAIT_ADROP: begin
                if (!address_in) begin
                    cout_d  = 1'b0;
                    bus_d   = 8'h00;
                    state_d = S_WAIT_ST;
                end else if (tmo) begin
                    err     = R_TIMEOUT;
                    state_d = S_DROP;
                end
            end
            S_WAIT_ST: begin
                if (status_in) begin
                    status_d = bus_in;
                    svc_d    = 1'b1;
                    state_d  = S_WAIT_SDROP;
                    if (!in_par_ok) err = R_PARITY;
                end else if (tmo) begin
                    err     = R_TIMEOUT;
                    state_d = S_DROP;
                end
            end
            S_WAIT_SDROP: begin
                if (!status_in) begin
                    state_d = S_DROP;
                end else if (tmo) begin
                    err     = R_TIMEOUT;
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                sel_d   = 1'b0;
                hold_d  = 1'b0;
                aout_d  = 1'b0;
                cout_d  = 1'b0;
                svc_d   = 1'b0;
                bus_d   = 8'h00;
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!operational_in) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (tmo) begin
                    err     = R_TIMEOUT;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Only the first error of a sequence is kept.
        if (err != R_OK && result_q == R_OK) result_d = err;
        if (!enable) begin
            state_d  = S_IDLE;
            bus_d    = 8'h00;
            aout_d   = 1'b0;
            sel_d    = 1'b0;
            hold_d   = 1'b0;
            cout_d   = 1'b0;
            svc_d    = 1'b0;
            done_d   = 1'b0;
            result_d = result_q;
            status_d = status_q;
        end
        if (state_d != state_q || state_q == S_IDLE || state_q == S_DROP) begin
            cnt_d = 16'd0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
        ready_d = enable && (state_d == S_IDLE) && !done_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 16'd0;
            addr_q   <= 8'h00;
            cmd_q    <= 8'h00;
            bus_q    <= 8'h00;
            par_q    <= 1'b0;
            status_q <= 8'h00;
            result_q <= R_OK;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            op_q     <= 1'b0;
            aout_q   <= 1'b0;
            sel_q    <= 1'b0;
            hold_q   <= 1'b0;
            cout_q   <= 1'b0;
            svc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            cmd_q    <= cmd_d;
            bus_q    <= bus_d;
            par_q    <= ~^bus_d;
            status_q <= status_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            op_q     <= enable;
            aout_q   <= aout_d;
            sel_q    <= sel_d;
            hold_q   <= hold_d;
            cout_q   <= cout_d;
            svc_q    <= svc_d;
        end
    end

    assign ready           = ready_q;
    assign done            = done_q;
    assign result          = result_q;
    assign status          = status_q;
    assign bus_out         = bus_q;
    assign bus_out_parity  = par_q;
    assign operational_out = op_q;
    assign address_out     = aout_q;
    assign select_out      = sel_q;
    assign hold_out        = hold_q;
    assign command_out     = cout_q;
    assign service_out     = svc_q;

endmodule
